// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared constants, arctangent table and stage record for the CORDIC kernel
package cordic_pkg;
  localparam int CORDIC_DATA_WIDTH  = 16;
  localparam int CORDIC_ITERATIONS  = 16;
  localparam int CORDIC_THETA_WIDTH = 16;
  localparam int CORDIC_MAX_ITER    = 32;
  localparam int CORDIC_GAIN_COMP   = 19898;
  localparam int CORDIC_GAIN_SHIFT  = 15;

  // round(atan(2^-k) * 2^15 / pi): micro-rotation angles for a 16-bit binary angle
  localparam int CORDIC_ATAN16 [0:CORDIC_MAX_ITER-1] = '{
    8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5, 3, 1, 1, 0,
    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0
  };

  typedef struct packed {
    logic signed [CORDIC_DATA_WIDTH+1:0]  x;
    logic signed [CORDIC_DATA_WIDTH+1:0]  y;
    logic signed [CORDIC_THETA_WIDTH-1:0] z;
    logic                                 valid;
  } cordic_stage_t;

  function automatic int cordic_atan(input int k, input int theta_width);
    int v;
    v = (k < CORDIC_MAX_ITER) ? CORDIC_ATAN16[k[4:0]] : 0;
    if (theta_width >= 16) return v <<< (theta_width - 16);
    return (v + (1 <<< (15 - theta_width))) >>> (16 - theta_width);
  endfunction
endpackage

// File: rtl/cordic_stage.sv
// rtl/cordic_stage.sv - one registered vectoring micro-rotation, stage index K
module cordic_stage
  import cordic_pkg::*;
#(
  parameter int XY_WIDTH    = CORDIC_DATA_WIDTH + 2,
  parameter int THETA_WIDTH = CORDIC_THETA_WIDTH,
  parameter int K           = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic signed [XY_WIDTH-1:0]    i_x,
  input  logic signed [XY_WIDTH-1:0]    i_y,
  input  logic signed [THETA_WIDTH-1:0] i_z,
  input  logic                          i_valid,
  input  logic                          i_zero,
  output logic signed [XY_WIDTH-1:0]    o_x,
  output logic signed [XY_WIDTH-1:0]    o_y,
  output logic signed [THETA_WIDTH-1:0] o_z,
  output logic                          o_valid,
  output logic                          o_zero
);
  localparam logic signed [THETA_WIDTH-1:0] ATAN_K = THETA_WIDTH'(cordic_atan(K, THETA_WIDTH));

  logic signed [XY_WIDTH-1:0] w_x_sh;
  logic signed [XY_WIDTH-1:0] w_y_sh;

  assign w_x_sh = i_x >>> K;
  assign w_y_sh = i_y >>> K;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_x     <= '0;
      o_y     <= '0;
      o_z     <= '0;
      o_valid <= 1'b0;
      o_zero  <= 1'b0;
    end else begin
      o_valid <= i_valid;
      o_zero  <= i_zero;
      // Rotate towards the positive x axis, accumulating the angle removed
      if (!i_y[XY_WIDTH-1]) begin
        o_x <= i_x + w_y_sh;
        o_y <= i_y - w_x_sh;
        o_z <= i_z + ATAN_K;
      end else begin
        o_x <= i_x - w_y_sh;
        o_y <= i_y + w_x_sh;
        o_z <= i_z - ATAN_K;
      end
    end
  end
endmodule

// File: rtl/cordic_vectoring_kernel.sv
// rtl/cordic_vectoring_kernel.sv - pipelined vectoring CORDIC, (I,Q) -> magnitude and atan2 phase
// Define CORDIC_GAIN_COMP_EN to add a registered 1/K gain-compensation stage.
module cordic_vectoring_kernel
  import cordic_pkg::*;
#(
  parameter int DATA_WIDTH  = CORDIC_DATA_WIDTH,
  parameter int ITERATIONS  = CORDIC_ITERATIONS,
  parameter int THETA_WIDTH = CORDIC_THETA_WIDTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic signed [DATA_WIDTH-1:0]  data_i,
  input  logic signed [DATA_WIDTH-1:0]  data_q,
  input  logic                          enable,
  output logic signed [DATA_WIDTH+1:0]  output_data_i,
  output logic signed [DATA_WIDTH+1:0]  output_data_q,
  output logic signed [THETA_WIDTH-1:0] output_data_theta,
  output logic                          output_data_valid
);
  localparam int XW = DATA_WIDTH + 2;
  localparam logic signed [THETA_WIDTH-1:0] HALF_PI = {2'b01, {(THETA_WIDTH-2){1'b0}}};

  logic signed [XW-1:0]          w_x     [0:ITERATIONS];
  logic signed [XW-1:0]          w_y     [0:ITERATIONS];
  logic signed [THETA_WIDTH-1:0] w_z     [0:ITERATIONS];
  logic                          w_valid [0:ITERATIONS];
  logic                          w_zero  [0:ITERATIONS];
  logic signed [XW-1:0]          w_i_ext;
  logic signed [XW-1:0]          w_q_ext;

  logic signed [XW-1:0]          r_x0;
  logic signed [XW-1:0]          r_y0;
  logic signed [THETA_WIDTH-1:0] r_z0;
  logic                          r_valid0;
  logic                          r_zero0;

  assign w_i_ext = XW'(data_i);
  assign w_q_ext = XW'(data_q);

  // Quadrant pre-rotation brings the vector into the right half-plane; an all-zero
  // input is flagged so the phase can be forced to 0 where the iterations cannot converge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_x0     <= '0;
      r_y0     <= '0;
      r_z0     <= '0;
      r_valid0 <= 1'b0;
      r_zero0  <= 1'b0;
    end else begin
      r_valid0 <= enable;
      r_zero0  <= (data_i == '0) && (data_q == '0);
      if (!data_i[DATA_WIDTH-1]) begin
        r_x0 <= w_i_ext;
        r_y0 <= w_q_ext;
        r_z0 <= '0;
      end else if (!data_q[DATA_WIDTH-1]) begin
        r_x0 <= w_q_ext;
        r_y0 <= -w_i_ext;
        r_z0 <= HALF_PI;
      end else begin
        r_x0 <= -w_q_ext;
        r_y0 <= w_i_ext;
        r_z0 <= -HALF_PI;
      end
    end
  end

  assign w_x[0]     = r_x0;
  assign w_y[0]     = r_y0;
  assign w_z[0]     = r_z0;
  assign w_valid[0] = r_valid0;
  assign w_zero[0]  = r_zero0;

  for (genvar k = 0; k < ITERATIONS; k++) begin : g_stage
    cordic_stage #(
      .XY_WIDTH    (XW),
      .THETA_WIDTH (THETA_WIDTH),
      .K           (k)
    ) u_stage (
      .clk     (clk),
      .reset   (reset),
      .i_x     (w_x[k]),
      .i_y     (w_y[k]),
      .i_z     (w_z[k]),
      .i_valid (w_valid[k]),
      .i_zero  (w_zero[k]),
      .o_x     (w_x[k+1]),
      .o_y     (w_y[k+1]),
      .o_z     (w_z[k+1]),
      .o_valid (w_valid[k+1]),
      .o_zero  (w_zero[k+1])
    );
  end

`ifdef CORDIC_GAIN_COMP_EN
  localparam int PW = XW + 17;
  localparam logic signed [PW-1:0] GAIN_COMP = PW'(CORDIC_GAIN_COMP);
  localparam logic signed [PW-1:0] HALF_LSB  = PW'(1 << (CORDIC_GAIN_SHIFT - 1));

  logic signed [PW-1:0]          w_prod;
  logic signed [XW-1:0]          r_mag;
  logic signed [XW-1:0]          r_res;
  logic signed [THETA_WIDTH-1:0] r_theta;
  logic                          r_valid;

  assign w_prod = PW'(w_x[ITERATIONS]) * GAIN_COMP + HALF_LSB;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mag   <= '0;
      r_res   <= '0;
      r_theta <= '0;
      r_valid <= 1'b0;
    end else begin
      r_mag   <= XW'(w_prod >>> CORDIC_GAIN_SHIFT);
      r_res   <= w_y[ITERATIONS];
      r_theta <= w_zero[ITERATIONS] ? '0 : w_z[ITERATIONS];
      r_valid <= w_valid[ITERATIONS];
    end
  end

  assign output_data_i     = r_mag;
  assign output_data_q     = r_res;
  assign output_data_theta = r_theta;
  assign output_data_valid = r_valid;
`else
  assign output_data_i     = w_x[ITERATIONS];
  assign output_data_q     = w_y[ITERATIONS];
  assign output_data_theta = w_zero[ITERATIONS] ? '0 : w_z[ITERATIONS];
  assign output_data_valid = w_valid[ITERATIONS];
`endif
endmodule

// File: tb/tb_cordic_vectoring_kernel.sv
// tb/tb_cordic_vectoring_kernel.sv - self-checking bench for cordic_vectoring_kernel
module tb_cordic_vectoring_kernel;
  localparam int DW = 16;
  localparam int IT = 16;
  localparam int TW = 16;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int  LAT  = IT + 2;
  localparam real GAIN = 1.0;
`else
  localparam int  LAT  = IT + 1;
  localparam real GAIN = 1.646760258;
`endif
  localparam real PI    = 3.14159265358979;
  localparam int  NRAND = 64;
  localparam int  NVEC  = 9;

  typedef struct {
    int  i;
    int  q;
    real th;
    real th_tol;
    real mag;
    real mag_tol;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 reset;
  logic signed [DW-1:0] data_i;
  logic signed [DW-1:0] data_q;
  logic                 enable;
  logic signed [DW+1:0] output_data_i;
  logic signed [DW+1:0] output_data_q;
  logic signed [TW-1:0] output_data_theta;
  logic                 output_data_valid;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t vecs [NVEC];
  int   ri   [NRAND];
  int   rq   [NRAND];
  bit   ren  [NRAND];

  cordic_vectoring_kernel #(
    .DATA_WIDTH  (DW),
    .ITERATIONS  (IT),
    .THETA_WIDTH (TW)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .data_i            (data_i),
    .data_q            (data_q),
    .enable            (enable),
    .output_data_i     (output_data_i),
    .output_data_q     (output_data_q),
    .output_data_theta (output_data_theta),
    .output_data_valid (output_data_valid)
  );

  always #5 clk = ~clk;

  task automatic check_near(input string name, input real act, input real exp, input real tol);
    n_checks++;
    if ((act - exp > tol) || (exp - act > tol)) begin
      n_fail++;
      $display("FAIL %s: got %0.2f expected %0.2f (tol %0.2f)", name, act, exp, tol);
    end
  endtask

  task automatic check_theta(input string name, input int act, input real exp, input real tol);
    real d;
    d = real'(act) - exp;
    while (d >= 32768.0) d = d - 65536.0;
    while (d < -32768.0) d = d + 65536.0;
    n_checks++;
    if (d > tol || d < -tol) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0.2f (tol %0.2f, mod 2^16)", name, act, exp, tol);
    end
  endtask

  function automatic real model_mag(input int i, input int q);
    return $sqrt(real'(i) * real'(i) + real'(q) * real'(q)) * GAIN;
  endfunction

  function automatic real model_theta(input int i, input int q);
    if (i == 0 && q == 0) return 0.0;
    return $atan2(real'(q), real'(i)) * 32768.0 / PI;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    bit seen;
    @(posedge clk); #1;
    data_i = DW'(v.i);
    data_q = DW'(v.q);
    enable = 1'b1;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk); #1;
      enable = 1'b0;
      lat++;
      @(negedge clk);
      if (output_data_valid) seen = 1'b1;
    end
    check_near($sformatf("vec%0d_latency", idx), real'(lat), real'(LAT), 0.0);
    if (seen) begin
      check_theta($sformatf("vec%0d_theta", idx), int'(output_data_theta), v.th, v.th_tol);
      check_near($sformatf("vec%0d_mag", idx), real'(int'(output_data_i)), v.mag * GAIN, v.mag_tol);
      check_near($sformatf("vec%0d_resid", idx), real'(int'(output_data_q)), 0.0, 8.0);
      @(negedge clk);
      check_near($sformatf("vec%0d_single_valid", idx), real'(output_data_valid), 0.0, 0.0);
    end
  endtask

  initial begin
    vecs[0] = '{i: 16384,  q: 0,      th: 0.0,      th_tol: 4.0, mag: 16384.0,   mag_tol: 8.0};
    vecs[1] = '{i: 0,      q: 16384,  th: 16384.0,  th_tol: 4.0, mag: 16384.0,   mag_tol: 8.0};
    vecs[2] = '{i: 0,      q: -16384, th: -16384.0, th_tol: 4.0, mag: 16384.0,   mag_tol: 8.0};
    vecs[3] = '{i: -16384, q: -16384, th: -24576.0, th_tol: 4.0, mag: 23170.475, mag_tol: 16.0};
    vecs[4] = '{i: -16384, q: 0,      th: -32768.0, th_tol: 4.0, mag: 16384.0,   mag_tol: 8.0};
    vecs[5] = '{i: 0,      q: 0,      th: 0.0,      th_tol: 0.0, mag: 0.0,       mag_tol: 0.0};
    vecs[6] = '{i: 16384,  q: 16384,  th: 8192.0,   th_tol: 4.0, mag: 23170.475, mag_tol: 16.0};
    vecs[7] = '{i: 32767,  q: -32768, th: -8192.0,  th_tol: 4.0, mag: 46340.26,  mag_tol: 16.0};
    vecs[8] = '{i: -32768, q: -32768, th: -24576.0, th_tol: 4.0, mag: 46340.95,  mag_tol: 16.0};

    reset  = 1'b0;
    enable = 1'b1;
    data_i = 16'sd1000;
    data_q = 16'sd2000;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_near($sformatf("rst_valid[%0d]", c), real'(output_data_valid), 0.0, 0.0);
      check_near($sformatf("rst_mag[%0d]", c), real'(int'(output_data_i)), 0.0, 0.0);
      check_near($sformatf("rst_theta[%0d]", c), real'(int'(output_data_theta)), 0.0, 0.0);
    end
    @(posedge clk); #1;
    reset  = 1'b1;
    enable = 1'b0;

    for (int v = 0; v < NVEC; v++) run_vec(vecs[v], v);

    for (int n = 0; n < NRAND; n++) begin
      int a, b, tries;
      ren[n] = ($urandom_range(0, 1) == 1);
      tries = 0;
      do begin
        a = int'($urandom_range(0, 65535)) - 32768;
        b = int'($urandom_range(0, 65535)) - 32768;
        tries++;
      end while ((real'(a) * a + real'(b) * b < 8192.0 * 8192.0) && tries < 100);
      if (tries >= 100) begin a = 16384; b = 0; end
      ri[n] = a;
      rq[n] = b;
    end
    for (int j = 0; j < NRAND + LAT + 2; j++) begin
      bit exp_v;
      int n;
      @(posedge clk); #1;
      if (j < NRAND) begin
        data_i = DW'(ri[j]);
        data_q = DW'(rq[j]);
        enable = ren[j];
      end else begin
        enable = 1'b0;
      end
      @(negedge clk);
      n = j - LAT;
      exp_v = (n >= 0 && n < NRAND) ? ren[n] : 1'b0;
      check_near($sformatf("rnd_valid[%0d]", j), real'(output_data_valid), real'(exp_v), 0.0);
      if (exp_v && output_data_valid) begin
        real m;
        m = model_mag(ri[n], rq[n]);
        check_theta($sformatf("rnd_theta[%0d]", n), int'(output_data_theta), model_theta(ri[n], rq[n]), 4.0);
        check_near($sformatf("rnd_mag[%0d]", n), real'(int'(output_data_i)), m,
                   (m * 0.001 > 8.0) ? m * 0.001 : 8.0);
      end
    end

    @(posedge clk); #1;
    data_i = 16'sd16384;
    data_q = 16'sd0;
    enable = 1'b1;
    repeat (LAT + 2) @(posedge clk);
    @(negedge clk);
    check_near("mid_valid_before_reset", real'(output_data_valid), 1.0, 0.0);
    #2 reset = 1'b0;
    #1;
    check_near("mid_valid_async_clear", real'(output_data_valid), 0.0, 0.0);
    check_near("mid_mag_async_clear", real'(int'(output_data_i)), 0.0, 0.0);
    @(posedge clk); #1;
    enable = 1'b0;
    reset  = 1'b1;
    begin
      int seen_cnt;
      seen_cnt = 0;
      for (int c = 0; c < LAT + 3; c++) begin
        @(negedge clk);
        if (output_data_valid) seen_cnt++;
      end
      check_near("mid_inflight_discarded", real'(seen_cnt), 0.0, 0.0);
    end
    run_vec(vecs[0], 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
